// File: rtl/reg_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter:
// widths, requester indices and FSM state encodings.
package cpu_pkg;

   localparam int DW = 32;
   localparam int AW = 5;

   localparam logic [1:0] REQ_ALU = 2'd0;
   localparam logic [1:0] REQ_LD  = 2'd1;
   localparam logic [1:0] REQ_DBG = 2'd2;

   localparam logic [0:0] ST_RR   = 1'b0;
   localparam logic [0:0] ST_LOCK = 1'b1;

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Writeback bus between the three requesters, the arbiter and the register file.
interface reg_wb_arbiter_if #(
   parameter int DW = cpu_pkg::DW,
   parameter int AW = cpu_pkg::AW
);
   logic [2:0]      ReqV;
   logic [3*AW-1:0] ReqRw;
   logic [3*DW-1:0] ReqData;
   logic [2:0]      ReqRdy;
   logic            Lock;
   logic            Locked;
   logic            RegWr;
   logic [AW-1:0]   Rw;
   logic [DW-1:0]   busW;

   modport master (
      output ReqV, ReqRw, ReqData, Lock,
      input  ReqRdy, Locked, RegWr, Rw, busW
   );

   modport slave (
      input  ReqV, ReqRw, ReqData, Lock,
      output ReqRdy, Locked, RegWr, Rw, busW
   );
endinterface

// File: rtl/reg_wb_arbiter_rr_pick3.sv
// Combinational three-way round-robin picker; in lock mode only the debug
// requester is eligible. Output is one-hot or zero.
module rr_pick3 (
   input  logic [2:0] i_valid,
   input  logic [1:0] i_last,
   input  logic       i_lock,
   output logic [2:0] o_grant
);
   import cpu_pkg::*;

   function automatic logic [2:0] first3(input logic [2:0] v,
                                         input logic [1:0] a,
                                         input logic [1:0] b,
                                         input logic [1:0] c);
      logic [2:0] g;
      g = 3'b000;
      if (v[a])      g = 3'b001 << a;
      else if (v[b]) g = 3'b001 << b;
      else if (v[c]) g = 3'b001 << c;
      else           g = 3'b000;
      return g;
   endfunction

   // search starts one past the last granted index
   always_comb begin
      o_grant = 3'b000;
      if (i_lock) begin
         o_grant = {i_valid[REQ_DBG], 2'b00};
      end else begin
         case (i_last)
            2'd0:    o_grant = first3(i_valid, 2'd1, 2'd2, 2'd0);
            2'd1:    o_grant = first3(i_valid, 2'd2, 2'd0, 2'd1);
            default: o_grant = first3(i_valid, 2'd0, 2'd1, 2'd2);
         endcase
      end
   end
endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the register file's single write port among ALU, load and debug
// requesters; RegWr/Rw/busW are registered on posedge for a negedge write.
module reg_wb_arbiter #(
   parameter int DW = cpu_pkg::DW,
   parameter int AW = cpu_pkg::AW
) (
   input logic              Clk,
   input logic              Reset,
   reg_wb_arbiter_if.slave  bus
);
   import cpu_pkg::*;

   logic [0:0]    r_state;
   logic [1:0]    r_last;
   logic          r_regwr;
   logic [AW-1:0] r_rw;
   logic [DW-1:0] r_busw;

   logic          w_lock_mode;
   logic [2:0]    w_pick;
   logic [2:0]    w_grant;
   logic          w_hs;
   logic [1:0]    w_idx;
   logic [AW-1:0] w_sel_rw;
   logic [DW-1:0] w_sel_data;

   assign w_lock_mode = (r_state == ST_LOCK);

   rr_pick3 u_pick (
      .i_valid (bus.ReqV),
      .i_last  (r_last),
      .i_lock  (w_lock_mode),
      .o_grant (w_pick)
   );

   // no grant may escape while reset is held
   assign w_grant    = Reset ? 3'b000 : w_pick;
   assign w_hs       = |w_grant;
   assign bus.ReqRdy = w_grant;
   assign bus.Locked = w_lock_mode;
   assign bus.RegWr  = r_regwr;
   assign bus.Rw     = r_rw;
   assign bus.busW   = r_busw;

   always_comb begin
      w_idx      = r_last;
      w_sel_rw   = '0;
      w_sel_data = '0;
      case (w_grant)
         3'b001: begin
            w_idx      = REQ_ALU;
            w_sel_rw   = bus.ReqRw[0*AW +: AW];
            w_sel_data = bus.ReqData[0*DW +: DW];
         end
         3'b010: begin
            w_idx      = REQ_LD;
            w_sel_rw   = bus.ReqRw[1*AW +: AW];
            w_sel_data = bus.ReqData[1*DW +: DW];
         end
         3'b100: begin
            w_idx      = REQ_DBG;
            w_sel_rw   = bus.ReqRw[2*AW +: AW];
            w_sel_data = bus.ReqData[2*DW +: DW];
         end
         default: begin
            w_idx      = r_last;
            w_sel_rw   = '0;
            w_sel_data = '0;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= ST_RR;
      end else begin
         case (r_state)
            ST_RR:   r_state <= bus.Lock ? ST_LOCK : ST_RR;
            ST_LOCK: r_state <= bus.Lock ? ST_LOCK : ST_RR;
            default: r_state <= ST_RR;
         endcase
      end
   end

   // pointer is frozen while locked so RR resumes where it left off
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_last <= 2'd2;
      end else if (w_hs && !w_lock_mode) begin
         r_last <= w_idx;
      end else begin
         r_last <= r_last;
      end
   end

   // writes to register 0 complete the handshake but never assert RegWr
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_regwr <= 1'b0;
         r_rw    <= '0;
         r_busw  <= '0;
      end else if (w_hs) begin
         r_regwr <= (w_sel_rw != '0);
         r_rw    <= w_sel_rw;
         r_busw  <= w_sel_data;
      end else begin
         r_regwr <= 1'b0;
         r_rw    <= r_rw;
         r_busw  <= r_busw;
      end
   end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter with a negedge-writing register file model.
module tb_reg_wb_arbiter;
   logic Clk   = 1'b0;
   logic Reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   reg_wb_arbiter_if #(.DW(32), .AW(5)) bus ();

   reg_wb_arbiter #(.DW(32), .AW(5)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   logic [31:0] regs [32] = '{default: 32'h0};

   always @(negedge Clk) begin
      if (bus.RegWr) regs[bus.Rw] <= bus.busW;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_req(input logic [2:0] v,
                          input logic [4:0] rw0, input logic [4:0] rw1, input logic [4:0] rw2,
                          input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
      bus.ReqV    = v;
      bus.ReqRw   = {rw2, rw1, rw0};
      bus.ReqData = {d2, d1, d0};
   endtask

   logic [2:0]  exp_grant [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
   logic [4:0]  exp_rw    [6] = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
   logic [31:0] exp_data  [6] = '{32'h1000, 32'h2000, 32'h3000, 32'h1000, 32'h2000, 32'h3000};

   initial begin
      bus.Lock = 1'b0;
      set_req(3'b111, 5'd1, 5'd2, 5'd3, 32'h1000, 32'h2000, 32'h3000);
      #2;
      chk("rst_regwr",  {31'd0, bus.RegWr},  32'd0);
      chk("rst_rw",     {27'd0, bus.Rw},     32'd0);
      chk("rst_busw",   bus.busW,            32'd0);
      chk("rst_locked", {31'd0, bus.Locked}, 32'd0);
      chk("rst_reqrdy", {29'd0, bus.ReqRdy}, 32'd0);
      tick();
      tick();
      Reset = 1'b0;
      settle();
      chk("post_rst_reqrdy", {29'd0, bus.ReqRdy}, 32'h1);

      for (int k = 0; k < 6; k++) begin
         chk($sformatf("rr_grant%0d", k), {29'd0, bus.ReqRdy}, {29'd0, exp_grant[k]});
         tick();
         chk($sformatf("rr_regwr%0d", k), {31'd0, bus.RegWr}, 32'd1);
         chk($sformatf("rr_rw%0d", k),    {27'd0, bus.Rw},    {27'd0, exp_rw[k]});
         chk($sformatf("rr_busw%0d", k),  bus.busW,           exp_data[k]);
      end

      set_req(3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'hDEAD, 32'h0);
      settle();
      chk("r0_reqrdy", {29'd0, bus.ReqRdy}, 32'h2);
      tick();
      chk("r0_regwr", {31'd0, bus.RegWr}, 32'd0);
      chk("r0_rw",    {27'd0, bus.Rw},    32'd0);
      chk("r0_busw",  bus.busW,           32'hDEAD);
      @(negedge Clk);
      #1;
      chk("r0_regfile", regs[0], 32'h0);

      set_req(3'b010, 5'd0, 5'd4, 5'd0, 32'h0, 32'h63, 32'h0);
      settle();
      chk("single_reqrdy", {29'd0, bus.ReqRdy}, 32'h2);
      tick();
      chk("single_regwr", {31'd0, bus.RegWr}, 32'd1);
      chk("single_rw",    {27'd0, bus.Rw},    32'd4);
      chk("single_busw",  bus.busW,           32'h63);
      @(negedge Clk);
      #1;
      chk("single_regfile", regs[4], 32'h63);

      set_req(3'b001, 5'd5, 5'd0, 5'd0, 32'h55, 32'h0, 32'h0);
      settle();
      chk("alu_reqrdy", {29'd0, bus.ReqRdy}, 32'h1);
      tick();
      chk("alu_rw", {27'd0, bus.Rw}, 32'd5);

      bus.Lock = 1'b1;
      set_req(3'b111, 5'd1, 5'd2, 5'd3, 32'h1000, 32'h2000, 32'h3000);
      settle();
      chk("lock_first_rr",   {29'd0, bus.ReqRdy}, 32'h2);
      chk("lock_first_lckd", {31'd0, bus.Locked}, 32'd0);
      tick();
      chk("lock_locked", {31'd0, bus.Locked}, 32'd1);
      chk("lock_rw_rr",  {27'd0, bus.Rw},     32'd2);
      chk("lock_grant1", {29'd0, bus.ReqRdy}, 32'h4);
      tick();
      chk("lock_rw_dbg", {27'd0, bus.Rw},     32'd3);
      chk("lock_grant2", {29'd0, bus.ReqRdy}, 32'h4);
      bus.Lock = 1'b0;
      settle();
      chk("unlock_last_grant", {29'd0, bus.ReqRdy}, 32'h4);
      chk("unlock_last_lckd",  {31'd0, bus.Locked}, 32'd1);
      tick();
      chk("unlock_locked",  {31'd0, bus.Locked}, 32'd0);
      chk("unlock_rw",      {27'd0, bus.Rw},     32'd3);
      chk("resume_grant1",  {29'd0, bus.ReqRdy}, 32'h4);
      tick();
      chk("resume_grant2",  {29'd0, bus.ReqRdy}, 32'h1);

      set_req(3'b111, 5'd1, 5'd2, 5'd3, 32'hABCD, 32'h2000, 32'h3000);
      settle();
      tick();
      chk("pre_rst_regwr", {31'd0, bus.RegWr}, 32'd1);
      chk("pre_rst_rw",    {27'd0, bus.Rw},    32'd1);
      chk("pre_rst_busw",  bus.busW,           32'hABCD);
      Reset = 1'b1;
      settle();
      chk("mid_rst_regwr",  {31'd0, bus.RegWr},  32'd0);
      chk("mid_rst_rw",     {27'd0, bus.Rw},     32'd0);
      chk("mid_rst_busw",   bus.busW,            32'd0);
      chk("mid_rst_reqrdy", {29'd0, bus.ReqRdy}, 32'd0);
      @(negedge Clk);
      #1;
      chk("mid_rst_regfile", regs[1], 32'h1000);
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      settle();
      chk("rerst_reqrdy", {29'd0, bus.ReqRdy}, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
